// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, widths and helpers for the display arbiter
package display_pkg;

  localparam int DISP_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    OPEN = 1'b0,
    HOLD = 1'b1
  } disp_arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - request/grant and display-driver bundle between sources and the arbiter
interface display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import display_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DISP_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [DISP_W-1:0]         disp_number;
  logic                      disp_load;
  logic [IDX_W-1:0]          owner_id;
  logic                      owner_valid;
  logic                      busy;

  modport master (
    output req, req_data,
    input  grant, disp_number, disp_load, owner_id, owner_valid, busy
  );

  modport slave (
    input  req, req_data,
    output grant, disp_number, disp_load, owner_id, owner_valid, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after base, wrapping
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] base,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_valid
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    int                idx;
    logic [IDX_W-1:0]  idx_v;
    winner    = base;
    any_valid = |req;
    idx       = 0;
    idx_v     = '0;
    // Scan from the farthest offset back to base so the nearest request wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      idx_v = IDX_W'(idx);
      if (req[idx_v]) winner = idx_v;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the seven-segment display with a minimum hold window
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  display_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  disp_arb_state_t    state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   base, base_n;
  logic [IDX_W-1:0]   win;
  logic               any_req;
  logic [NUM_REQ-1:0] req_live;

  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic               load_q, load_n;
  logic [DISP_W-1:0]  number_q, number_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic               valid_q, valid_n;

  logic [DISP_W-1:0]  data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_arr[i] = bus.req_data[DISP_W*i +: DISP_W];
  end

  // A source that is being granted this cycle is still holding req; don't count it twice.
  assign req_live = bus.req & ~grant_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_live),
    .base      (base),
    .winner    (win),
    .any_valid (any_req)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    base_n   = base;
    grant_n  = '0;
    load_n   = 1'b0;
    number_n = number_q;
    owner_n  = owner_q;
    valid_n  = valid_q;
    case (state)
      OPEN: begin
        if (any_req) begin
          number_n = data_arr[win];
          load_n   = 1'b1;
          grant_n  = NUM_REQ'(onehot(3'(win)));
          owner_n  = win;
          valid_n  = 1'b1;
          base_n   = (int'(win) == NUM_REQ - 1) ? '0 : win + IDX_W'(1);
          cnt_n    = '0;
          state_n  = HOLD;
        end
      end
      HOLD: begin
        cnt_n = cnt + CNT_W'(1);
        // The owner may refresh its value without extending the window.
        if (req_live[owner_q]) begin
          number_n = data_arr[owner_q];
          load_n   = 1'b1;
          grant_n  = NUM_REQ'(onehot(3'(owner_q)));
        end
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_n = OPEN;
          cnt_n   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OPEN;
      cnt      <= '0;
      base     <= '0;
      grant_q  <= '0;
      load_q   <= 1'b0;
      number_q <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      base     <= base_n;
      grant_q  <= grant_n;
      load_q   <= load_n;
      number_q <= number_n;
      owner_q  <= owner_n;
      valid_q  <= valid_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.disp_load   = load_q;
  assign bus.disp_number = number_q;
  assign bus.owner_id    = owner_q;
  assign bus.owner_valid = valid_q;
  assign bus.busy        = (state == HOLD);

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed and randomized checks of display_arbiter against a cycle model
module tb_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HOLD    = 8;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  display_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: hold_left counts the remaining on-screen cycles of the current owner.
  int          m_base, m_owner, m_hold_left;
  bit          m_valid, m_load;
  logic [3:0]  m_grant;
  logic [31:0] m_number;

  task automatic model_tick();
    int         win;
    logic [3:0] live;
    if (!rst_n) begin
      m_base = 0; m_owner = 0; m_hold_left = 0;
      m_valid = 0; m_load = 0; m_grant = '0; m_number = '0;
    end else begin
      live = bus.req & ~m_grant;
      win  = -1;
      if (m_hold_left == 0) begin
        for (int k = 0; k < NUM_REQ; k++)
          if (win < 0 && live[(m_base + k) % NUM_REQ]) win = (m_base + k) % NUM_REQ;
        if (win >= 0) begin
          m_owner     = win;
          m_base      = (win + 1) % NUM_REQ;
          m_hold_left = HOLD;
        end
      end else begin
        if (live[m_owner]) win = m_owner;
        m_hold_left--;
      end
      m_grant = '0;
      m_load  = 0;
      if (win >= 0) begin
        m_grant[win] = 1'b1;
        m_load       = 1;
        m_number     = bus.req_data[32*win +: 32];
        m_valid      = 1;
      end
    end
  endtask

  function automatic logic [40:0] exp_vec();
    return {m_grant, m_load, m_number, 2'(m_owner), m_valid, (m_hold_left > 0)};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {bus.grant, bus.disp_load, bus.disp_number, bus.owner_id, bus.owner_valid, bus.busy};
  endfunction

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.req_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (dut_vec() !== 41'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.disp_load !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: got grant %b load %b busy %b want 0 0 0",
                        bus.grant, bus.disp_load, bus.busy);
    end
  endtask

  task automatic test_single_grant();
    int busy_cnt;
    do_reset();
    bus.req_data[95:64] = 32'hDEAD_BEEF;
    bus.req[2] = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec() !== {4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL single_grant: got %h want %h", dut_vec(),
                        {4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b1});
    end
    busy_cnt = 1;
    tick();
    bus.req[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL single_hold_c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    n_cmp++;
    if (busy_cnt != HOLD) begin
      n_bad++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, HOLD);
    end
  endtask

  task automatic test_round_robin();
    int         order[$];
    int         when[$];
    logic [3:0] prev_g;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[32*i +: 32] = $urandom;
    bus.req = 4'b1111;
    prev_g = '0;
    for (int c = 0; c < 100 && order.size() < 5; c++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rr_model_c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (prev_g[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && !bus.busy) begin
          bus.req[i] = 1'b1;
          bus.req_data[32*i +: 32] = $urandom;
        end
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.grant[i] === 1'b1) begin order.push_back(i); when.push_back(c); end
      prev_g = bus.grant;
    end
    n_cmp++;
    if (order.size() != 5) begin
      n_bad++; $display("FAIL rr_count: got %0d grants want 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (order[k] != k % NUM_REQ) begin
          n_bad++; $display("FAIL rr_order_%0d: got %0d want %0d", k, order[k], k % NUM_REQ);
        end
        if (k > 0) begin
          n_cmp++;
          if (when[k] - when[k-1] != HOLD + 1) begin
            n_bad++; $display("FAIL rr_spacing_%0d: got %0d want %0d", k, when[k] - when[k-1], HOLD + 1);
          end
        end
      end
    end
  endtask

  task automatic test_owner_update();
    do_reset();
    bus.req_data[63:32] = $urandom;
    bus.req[1] = 1'b1;
    tick();                 // hold cycle 0: owner 1 granted
    tick();                 // hold cycle 1
    bus.req[1] = 1'b0;
    tick();                 // hold cycle 2
    tick();                 // hold cycle 3
    bus.req_data[63:32] = 32'h0000_0042;
    bus.req[1] = 1'b1;
    tick();                 // hold cycle 4
    n_cmp++;
    if (dut_vec() !== {4'b0010, 1'b1, 32'h0000_0042, 2'd1, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL owner_update: got %h want %h", dut_vec(),
                        {4'b0010, 1'b1, 32'h0000_0042, 2'd1, 1'b1, 1'b1});
    end
    tick();                 // hold cycle 5
    bus.req[1] = 1'b0;
    tick();
    tick();                 // hold cycle 7
    n_cmp++;
    if (bus.busy !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL owner_busy_last: got %h want %h", dut_vec(), exp_vec());
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      n_bad++; $display("FAIL owner_busy_fall: got busy %b grant %b want 0 0000", bus.busy, bus.grant);
    end
  endtask

  task automatic test_pending_other();
    int   early;
    logic busy_at_end;
    do_reset();
    bus.req_data[31:0] = $urandom;
    bus.req[0] = 1'b1;
    tick();                 // hold cycle 0
    tick();
    bus.req[0] = 1'b0;
    tick();                 // hold cycle 2
    bus.req_data[127:96] = $urandom;
    bus.req[3] = 1'b1;
    early = 0;
    busy_at_end = 1'b1;
    for (int h = 2; h <= 8; h++) begin
      if (bus.grant !== 4'b0000) early++;
      if (h == 8) busy_at_end = bus.busy;
      tick();
    end
    n_cmp++;
    if (early != 0 || busy_at_end !== 1'b0) begin
      n_bad++; $display("FAIL pending_blocked: got %0d early grants busy %b want 0 0", early, busy_at_end);
    end
    n_cmp++;
    if (bus.grant !== 4'b1000 || bus.owner_id !== 2'd3 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL pending_grant: got %h want grant 1000 owner 3 (%h)", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [31:0] d1;
    do_reset();
    bus.req_data[31:0] = $urandom;
    bus.req[0] = 1'b1;
    tick();                 // hold cycle 0
    tick();
    bus.req[0] = 1'b0;
    d1 = $urandom;
    bus.req_data[63:32] = d1;
    bus.req[1] = 1'b1;
    tick();
    tick();
    tick();                 // hold cycle 4
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (dut_vec() !== 41'd0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL midhold_reset: got %h want 0", dut_vec());
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec() !== {4'b0010, 1'b1, d1, 2'd1, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL midhold_regrant: got %h want %h", dut_vec(), {4'b0010, 1'b1, d1, 2'd1, 1'b1, 1'b1});
    end
  endtask

  task automatic test_last_cycle_update();
    logic [31:0] d0, d2;
    do_reset();
    bus.req_data[95:64] = $urandom;
    bus.req[2] = 1'b1;
    tick();                 // hold cycle 0
    tick();
    bus.req[2] = 1'b0;
    tick();                 // hold cycle 2
    d0 = $urandom;
    bus.req_data[31:0] = d0;
    bus.req[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();   // hold cycle 7
    d2 = $urandom;
    bus.req_data[95:64] = d2;
    bus.req[2] = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec() !== {4'b0100, 1'b1, d2, 2'd2, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL last_update: got %h want %h", dut_vec(), {4'b0100, 1'b1, d2, 2'd2, 1'b1, 1'b0});
    end
    tick();
    n_cmp++;
    if (dut_vec() !== {4'b0001, 1'b1, d0, 2'd0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL last_next_owner: got %h want %h", dut_vec(), {4'b0001, 1'b1, d0, 2'd0, 1'b1, 1'b1});
    end
    bus.req[2] = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] prev_g;
    do_reset();
    prev_g = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (prev_g[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_data[32*i +: 32] = $urandom;
        end
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      prev_g = bus.grant;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_owner_update();
    test_pending_other();
    test_reset_mid_hold();
    test_last_cycle_update();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
